// File: rtl/neuron_tick_scheduler.sv
// neuron_tick_scheduler: walks N virtual neurons through one shared update datapath per tick.
// Optional refractory gating is compiled in with `define SCHED_REFRACTORY_EN.
module neuron_tick_scheduler #(
    parameter int N_NEURONS     = 4,
    parameter int STATE_W       = 8,
    parameter int CUR_W         = 8,
    parameter int REFRACT_TICKS = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         clear,
    output logic                         busy,
    output logic                         done,
    output logic [N_NEURONS-1:0]         spike_vec,
    output logic [$clog2(N_NEURONS)-1:0] current_sel,
    input  logic [CUR_W-1:0]             current_in,
    output logic                         dp_req,
    input  logic                         dp_ack,
    output logic [STATE_W-1:0]           dp_state_o,
    output logic [CUR_W-1:0]             dp_current_o,
    input  logic [STATE_W-1:0]           dp_state_i,
    input  logic                         dp_spike_i
);

    localparam int IDX_W = $clog2(N_NEURONS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

    if (N_NEURONS < 2 || N_NEURONS > 16) begin : g_bad_n
        $error("neuron_tick_scheduler: N_NEURONS out of range");
    end
    if (REFRACT_TICKS < 1 || REFRACT_TICKS > 7) begin : g_bad_refract
        $error("neuron_tick_scheduler: REFRACT_TICKS out of range");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_NEXT,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [STATE_W-1:0]     st_q [N_NEURONS];
    logic [STATE_W-1:0]     st_d [N_NEURONS];
    logic [N_NEURONS-1:0]   acc_q, acc_d;
    logic [N_NEURONS-1:0]   spike_q, spike_d;

    logic refr_hit;
    logic adv;
    logic last;

`ifdef SCHED_REFRACTORY_EN
    localparam int RC_W = 3;
    localparam logic [RC_W-1:0] RC_LOAD = RC_W'(REFRACT_TICKS);

    logic [RC_W-1:0] rc_q [N_NEURONS];
    logic [RC_W-1:0] rc_d [N_NEURONS];

    assign refr_hit = (rc_q[idx_q] != '0);

    always_comb begin
        for (int i = 0; i < N_NEURONS; i++) begin
            rc_d[i] = rc_q[i];
        end
        if (state_q == S_IDLE && clear) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                rc_d[i] = '0;
            end
        end else if (adv) begin
            if (refr_hit) begin
                rc_d[idx_q] = rc_q[idx_q] - RC_W'(1);
            end else if (dp_spike_i) begin
                rc_d[idx_q] = RC_LOAD;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                rc_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_NEURONS; i++) begin
                rc_q[i] <= rc_d[i];
            end
        end
    end
`else
    assign refr_hit = 1'b0;
`endif

    // A refractory neuron takes the same single-cycle exit from REQ as an ack.
    assign adv  = (state_q == S_REQ) && (refr_hit || dp_ack);
    assign last = (idx_q == LAST_IDX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (!clear && start) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (adv) begin
                    state_d = last ? S_DONE : S_NEXT;
                end
            end
            S_NEXT:  state_d = S_REQ;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy   = 1'b1;
        done   = 1'b0;
        dp_req = 1'b0;
        unique case (state_q)
            S_IDLE:  busy = 1'b0;
            S_REQ:   dp_req = !refr_hit;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        idx_d   = idx_q;
        acc_d   = acc_q;
        spike_d = spike_q;
        for (int i = 0; i < N_NEURONS; i++) begin
            st_d[i] = st_q[i];
        end
        unique case (state_q)
            S_IDLE: begin
                if (clear) begin
                    for (int i = 0; i < N_NEURONS; i++) begin
                        st_d[i] = '0;
                    end
                end else if (start) begin
                    idx_d = '0;
                    acc_d = '0;
                end
            end
            S_REQ: begin
                if (adv) begin
                    st_d[idx_q]  = refr_hit ? '0 : dp_state_i;
                    acc_d[idx_q] = !refr_hit && dp_spike_i;
                    // Last neuron's bit lands in the same edge that publishes the vector.
                    if (last) begin
                        spike_d = acc_d;
                    end
                end
            end
            S_NEXT: begin
                idx_d = idx_q + IDX_W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q   <= '0;
            acc_q   <= '0;
            spike_q <= '0;
            for (int i = 0; i < N_NEURONS; i++) begin
                st_q[i] <= '0;
            end
        end else begin
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            spike_q <= spike_d;
            for (int i = 0; i < N_NEURONS; i++) begin
                st_q[i] <= st_d[i];
            end
        end
    end

    assign current_sel  = idx_q;
    assign spike_vec    = spike_q;
    assign dp_state_o   = st_q[idx_q];
    assign dp_current_o = dp_req ? current_in : '0;

endmodule

// File: doc/neuron_tick_scheduler.md
# neuron_tick_scheduler

Time-multiplexes a single neuron update datapath (LIF or linear HH step unit) across `N_NEURONS` virtual neurons. On each `start` pulse (one simulation tick), it walks all neuron indices in order. For each index it issues the stored membrane state and that neuron's input current to the datapath over a req/ack handshake, then writes back the new state and spike bit. It sits between the top-level I/O wrapper and one shared neuron datapath instance, and publishes a registered spike vector and a `done` pulse per tick.

## Interface
Parameters:
- `N_NEURONS`, 4: number of virtual neurons, 2..16.
- `STATE_W`, 8: membrane state width.
- `CUR_W`, 8: input current width.
- `REFRACT_TICKS`, 2: refractory length in ticks. Used only with `SCHED_REFRACTORY_EN`; range 1..7.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  tick request; sampled only in IDLE.
- `clear`  in  1  zeroes all stored states; sampled only in IDLE.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse when a tick completes.
- `spike_vec`  out  N_NEURONS  spike bits of the last completed tick; bit i is neuron i.
- `current_sel`  out  clog2(N_NEURONS)  index of the neuron currently being served.
- `current_in`  in  CUR_W  current for `current_sel`; the requester drives it combinationally.
- `dp_req`  out  1  datapath request.
- `dp_ack`  in  1  datapath result valid.
- `dp_state_o`  out  STATE_W  stored state of `current_sel`.
- `dp_current_o`  out  CUR_W  equals `current_in` while `dp_req`=1, else 0.
- `dp_state_i`  in  STATE_W  new state; valid when `dp_ack`=1.
- `dp_spike_i`  in  1  spike bit; valid when `dp_ack`=1.

## Operation
- Storage:
  - State register file `st[N_NEURONS]`, STATE_W each.
  - Spike accumulator `acc[N_NEURONS]`.
  - Index register `idx`.
- FSM states:
  - IDLE:
    - `clear`=1: all `st` ← 0 and `start` is ignored (clear has priority).
    - Otherwise `start`=1: `idx`←0, `acc`←0, go to REQ.
  - REQ:
    - `dp_req`=1; `dp_state_o`=`st[idx]`; `current_sel`=`idx`.
    - On an edge with `dp_ack`=1: `st[idx]`←`dp_state_i`, `acc[idx]`←`dp_spike_i`.
    - Then: if `idx`=N_NEURONS-1 go to DONE, else go to NEXT.
  - NEXT: `dp_req`=0; `idx`←`idx`+1; go to REQ.
  - DONE: `done`=1; `spike_vec`←`acc` (registered on the edge that enters DONE); next edge goes to IDLE.
- `dp_ack` in any state other than REQ is ignored.
- `start`/`clear` while `busy`=1 are ignored; they are not queued.
- `spike_vec` holds its value until the next DONE.
- Results from the datapath are written back unmodified; no saturation in this block.
- `dp_req` drops for at least one cycle between neurons (NEXT), so the datapath sees a fresh rising edge per request.

## Timing
- Reset values (asynchronous):
  - FSM = IDLE.
  - `busy`, `done`, `dp_req` = 0.
  - `spike_vec` = 0; `idx` = 0 (so `current_sel` = 0).
  - `dp_state_o` = 0 (it is `st[0]`, which resets to 0); `dp_current_o` = 0.
  - All `st`, `acc` = 0.
- Reset mid-tick aborts immediately. A partially written tick is discarded; all states are 0 after reset.
- `dp_req`, `dp_state_o` and `current_sel` are stable from REQ entry until the acked edge. The datapath may stall arbitrarily.
- Latency with `dp_ack` tied high: the edge sampling `start` is E0. REQ for neuron i is entered at edge E(2i). DONE is entered at E(2N_NEURONS-1). `done` is high for exactly one cycle. `busy` falls at E(2N_NEURONS).
- Each cycle of `dp_ack`=0 in REQ adds one cycle to the total latency.

## Configuration
- `SCHED_REFRACTORY_EN` defined:
  - Adds a per-neuron refractory counter, reset value 0.
  - Acked `dp_spike_i`=1 loads the counter with `REFRACT_TICKS`.
  - In REQ, if the counter is nonzero: `dp_req` stays 0, and the FSM spends exactly one cycle there. In that cycle `st[idx]`←0, `acc[idx]`←0 and the counter decrements. It then leaves REQ exactly as on an ack.
  - `clear` also zeroes the counters.
- `SCHED_REFRACTORY_EN` undefined: no counters; every neuron is issued every tick.

## Test plan
- Reset values:
  - Assert `reset` asynchronously mid-cycle, then release → `busy`=`done`=`dp_req`=0, `spike_vec`=0.
  - Next tick issues `dp_state_o`=0 for every index.
- Basic tick:
  - Setup: N=4, `dp_ack` tied high, datapath model returns state+current with spike at ≥200, currents 10/20/30/40.
  - Response: `done` follows 7 edges after the start edge; next tick issues states 10/20/30/40; `spike_vec`=0.
- Backpressure: hold `dp_ack` low 3 cycles on neuron 1 → `dp_req`, `dp_state_o` and `current_sel`=1 stay constant; `done` is delayed by exactly 3 cycles.
- Spike capture:
  - Datapath returns spike=1 for neuron 2 only → `spike_vec`=4'b0100 at `done`.
  - `spike_vec` holds that value through IDLE and returns to 0 only after the next tick's DONE.
- Ignored requests:
  - `start` pulsed while busy → no extra tick.
  - `clear` and `start` together in IDLE → states zeroed, no tick started.
- Mid-tick reset: assert `reset` in REQ for neuron 2 → immediate IDLE; `dp_req`=0; all states 0.
- Refractory (`SCHED_REFRACTORY_EN`, `REFRACT_TICKS`=2):
  - Neuron 2 spikes in tick 1 → ticks 2 and 3 show no `dp_req` for index 2, and its state reads 0.
  - Tick 4 issues neuron 2 again.
  - Without the macro, neuron 2 is issued in every tick.
